// File: rtl/puncture_depuncture_if.sv
// AXI-Stream style bundle (data, last, valid, ready) used on both sides of the
// puncture/depuncture engine.
interface puncture_depuncture_if #(
  parameter int WIDTH = 32
) ();
  logic [WIDTH-1:0] tdata;
  logic             tlast;
  logic             tvalid;
  logic             tready;

  modport master (output tdata, output tlast, output tvalid, input tready);
  modport slave  (input tdata, input tlast, input tvalid, output tready);
endinterface

// File: rtl/puncture_depuncture.sv
// Packet-aware puncture/depuncture engine with shadowed runtime configuration.
// Define PUNCTURE_DEPUNCTURE_STATS_EN to add dropped/inserted word counters.
module puncture_depuncture #(
  parameter int                 WIDTH          = 32,
  parameter int                 MAX_LEN        = 16,
  parameter int                 DEFAULT_LEN    = 8,
  parameter logic [MAX_LEN-1:0] DEFAULT_VECTOR = 16'h00FF,
  parameter bit                 DEFAULT_MODE   = 1'b0,
  parameter logic [WIDTH-1:0]   FILL_VALUE     = '0
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             clear_i,
  input  logic [$clog2(MAX_LEN+1)-1:0]     cfg_len_i,
  input  logic                             cfg_len_stb_i,
  input  logic [MAX_LEN-1:0]               cfg_vector_i,
  input  logic                             cfg_vector_stb_i,
  input  logic                             cfg_mode_i,
  input  logic                             cfg_mode_stb_i,
  puncture_depuncture_if.slave             s_axis,
  puncture_depuncture_if.master            m_axis,
`ifdef PUNCTURE_DEPUNCTURE_STATS_EN
  input  logic                             stat_clr_i,
  output logic [31:0]                      stat_dropped_o,
  output logic [31:0]                      stat_inserted_o,
`endif
  output logic                             in_packet_o
);
  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int EW = WIDTH + 1;

  logic               rst;
  logic [LW-1:0]      sh_len_q, sh_len_d, act_len_q, act_len_d, eff_len;
  logic [MAX_LEN-1:0] sh_vec_q, sh_vec_d, act_vec_q, act_vec_d, vec_eff;
  logic               sh_mode_q, sh_mode_d, act_mode_q, act_mode_d;
  logic [IW-1:0]      idx_q, idx_d, idx_next;
  logic               in_packet_q, in_packet_d, rdy_q;
  logic [WIDTH-1:0]   hold_q, hold_d;
  logic               hold_v_q, hold_v_d;
  logic [EW-1:0]      slot0_q, slot0_d, slot1_q, slot1_d, push0, push1;
  logic [1:0]         cnt_q, cnt_d;
  logic               push0_v, push1_v, pop, space_ok, cur_bit, accept, fill, commit;

  assign rst = reset | clear_i;

  assign eff_len  = (act_len_q == '0 || act_len_q > LW'(MAX_LEN)) ? LW'(MAX_LEN) : act_len_q;
  // An all-zero vector in depuncture mode would stall forever; treat it as all-ones.
  assign vec_eff  = (act_mode_q && act_vec_q == '0) ? '1 : act_vec_q;
  assign cur_bit  = vec_eff[idx_q];
  assign idx_next = (LW'(idx_q) == eff_len - LW'(1)) ? '0 : idx_q + IW'(1);

  // Input is only accepted when the output stage could take two words after this cycle's pop.
  assign pop      = (cnt_q != 2'd0) && m_axis.tready;
  assign space_ok = (cnt_q == 2'd0) || (cnt_q == 2'd1 && m_axis.tready);

  assign s_axis.tready = !rst && rdy_q && space_ok && (!act_mode_q || cur_bit);
  assign accept        = s_axis.tvalid && s_axis.tready;
  assign fill          = !rst && rdy_q && space_ok && act_mode_q && s_axis.tvalid && !cur_bit;

  assign m_axis.tvalid = (cnt_q != 2'd0);
  assign m_axis.tdata  = slot0_q[WIDTH-1:0];
  assign m_axis.tlast  = slot0_q[WIDTH];
  assign in_packet_o   = in_packet_q;

  always_comb begin
    hold_d   = hold_q;
    hold_v_d = hold_v_q;
    push0_v  = 1'b0;
    push1_v  = 1'b0;
    push0    = '0;
    push1    = '0;
    idx_d    = idx_q;
    if (accept) begin
      idx_d = s_axis.tlast ? '0 : idx_next;
      if (act_mode_q) begin
        push0_v = 1'b1;
        push0   = {s_axis.tlast, s_axis.tdata};
      end else if (s_axis.tlast) begin
        hold_v_d = 1'b0;
        if (cur_bit) begin
          push0_v = 1'b1;
          if (hold_v_q) begin
            push0   = {1'b0, hold_q};
            push1_v = 1'b1;
            push1   = {1'b1, s_axis.tdata};
          end else begin
            push0   = {1'b1, s_axis.tdata};
          end
        end else if (hold_v_q) begin
          push0_v = 1'b1;
          push0   = {1'b1, hold_q};
        end
      end else if (cur_bit) begin
        push0_v  = hold_v_q;
        push0    = {1'b0, hold_q};
        hold_d   = s_axis.tdata;
        hold_v_d = 1'b1;
      end
    end else if (fill) begin
      idx_d   = idx_next;
      push0_v = 1'b1;
      push0   = {1'b0, FILL_VALUE};
    end
  end

  always_comb begin
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    cnt_d   = cnt_q;
    if (pop) begin
      slot0_d = slot1_q;
      cnt_d   = cnt_q - 2'd1;
    end
    if (push0_v) begin
      if (cnt_d == 2'd0) slot0_d = push0;
      else               slot1_d = push0;
      cnt_d = cnt_d + 2'd1;
    end
    if (push1_v) begin
      if (cnt_d == 2'd0) slot0_d = push1;
      else               slot1_d = push1;
      cnt_d = cnt_d + 2'd1;
    end
  end

  // Commit uses the post-strobe shadow so a strobe in the commit cycle wins.
  always_comb begin
    sh_len_d    = cfg_len_stb_i    ? cfg_len_i    : sh_len_q;
    sh_vec_d    = cfg_vector_stb_i ? cfg_vector_i : sh_vec_q;
    sh_mode_d   = cfg_mode_stb_i   ? cfg_mode_i   : sh_mode_q;
    commit      = !in_packet_q && !accept;
    act_len_d   = commit ? sh_len_d  : act_len_q;
    act_vec_d   = commit ? sh_vec_d  : act_vec_q;
    act_mode_d  = commit ? sh_mode_d : act_mode_q;
    in_packet_d = accept ? !s_axis.tlast : in_packet_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_len_q    <= LW'(DEFAULT_LEN);
      sh_vec_q    <= DEFAULT_VECTOR;
      sh_mode_q   <= DEFAULT_MODE;
      act_len_q   <= LW'(DEFAULT_LEN);
      act_vec_q   <= DEFAULT_VECTOR;
      act_mode_q  <= DEFAULT_MODE;
      idx_q       <= '0;
      in_packet_q <= 1'b0;
      rdy_q       <= 1'b0;
      hold_q      <= '0;
      hold_v_q    <= 1'b0;
      slot0_q     <= '0;
      slot1_q     <= '0;
      cnt_q       <= 2'd0;
    end else begin
      sh_len_q    <= sh_len_d;
      sh_vec_q    <= sh_vec_d;
      sh_mode_q   <= sh_mode_d;
      act_len_q   <= act_len_d;
      act_vec_q   <= act_vec_d;
      act_mode_q  <= act_mode_d;
      idx_q       <= idx_d;
      in_packet_q <= in_packet_d;
      rdy_q       <= 1'b1;
      hold_q      <= hold_d;
      hold_v_q    <= hold_v_d;
      slot0_q     <= slot0_d;
      slot1_q     <= slot1_d;
      cnt_q       <= cnt_d;
    end
  end

`ifdef PUNCTURE_DEPUNCTURE_STATS_EN
  logic [31:0] dropped_q, inserted_q;
  logic        drop_ev;

  assign drop_ev         = accept && !act_mode_q && !cur_bit;
  assign stat_dropped_o  = dropped_q;
  assign stat_inserted_o = inserted_q;

  always_ff @(posedge clk) begin
    if (rst || stat_clr_i) begin
      dropped_q  <= '0;
      inserted_q <= '0;
    end else begin
      if (drop_ev && dropped_q != 32'hFFFF_FFFF)  dropped_q  <= dropped_q + 32'd1;
      if (fill && inserted_q != 32'hFFFF_FFFF)    inserted_q <= inserted_q + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_puncture_depuncture.sv
// Directed self-checking bench for puncture_depuncture: puncture, depuncture,
// reconfiguration between packets, random backpressure and mid-packet reset.
module tb_puncture_depuncture;
  logic        clk;
  logic        reset;
  logic        clear;
  logic [4:0]  cfg_len;
  logic        cfg_len_stb;
  logic [15:0] cfg_vector;
  logic        cfg_vector_stb;
  logic        cfg_mode;
  logic        cfg_mode_stb;
  logic        in_packet;
`ifdef PUNCTURE_DEPUNCTURE_STATS_EN
  logic        stat_clr;
  logic [31:0] stat_dropped, stat_inserted;
`endif

  puncture_depuncture_if #(.WIDTH(32)) s_if ();
  puncture_depuncture_if #(.WIDTH(32)) m_if ();

  puncture_depuncture dut (
    .clk              (clk),
    .reset            (reset),
    .clear_i          (clear),
    .cfg_len_i        (cfg_len),
    .cfg_len_stb_i    (cfg_len_stb),
    .cfg_vector_i     (cfg_vector),
    .cfg_vector_stb_i (cfg_vector_stb),
    .cfg_mode_i       (cfg_mode),
    .cfg_mode_stb_i   (cfg_mode_stb),
    .s_axis           (s_if),
    .m_axis           (m_if),
`ifdef PUNCTURE_DEPUNCTURE_STATS_EN
    .stat_clr_i       (stat_clr),
    .stat_dropped_o   (stat_dropped),
    .stat_inserted_o  (stat_inserted),
`endif
    .in_packet_o      (in_packet)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          total  = 0;
  int          passed = 0;
  int          stalls = 0;
  logic        rnd_en = 1'b0;
  logic [32:0] outq[$];
  logic [32:0] exp_q[$];

  localparam logic [31:0] FILL = 32'h0;

  always @(posedge clk) begin
    #1;
    m_if.tready = rnd_en ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  always @(negedge clk)
    if (!reset && m_if.tvalid && m_if.tready) outq.push_back({m_if.tlast, m_if.tdata});

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  task automatic send_beat(input logic [31:0] d, input logic l);
    int   w;
    logic ok;
    s_if.tdata = d; s_if.tlast = l; s_if.tvalid = 1'b1;
    w = 0; ok = 1'b0;
    while (!ok && w < 200) begin
      @(negedge clk); ok = s_if.tready;
      @(posedge clk); #1;
      if (!ok) w++;
    end
    s_if.tvalid = 1'b0; s_if.tlast = 1'b0;
    stalls += w;
    if (!ok) begin
      total++;
      $display("FAIL send_timeout data=%h not accepted within 200 cycles", d);
    end
  endtask

  task automatic send_pkt(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) send_beat(base + 32'(i), i == n - 1);
  endtask

  task automatic set_cfg(input logic [4:0] len, input logic [15:0] vec, input logic mode);
    cfg_len = len; cfg_vector = vec; cfg_mode = mode;
    cfg_len_stb = 1'b1; cfg_vector_stb = 1'b1; cfg_mode_stb = 1'b1;
    @(posedge clk); #1;
    cfg_len_stb = 1'b0; cfg_vector_stb = 1'b0; cfg_mode_stb = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic drain(input int n);
    int t;
    t = 0;
    while (outq.size() < n && t < 300) begin @(posedge clk); t++; end
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    total++; if (m_if.tvalid !== 1'b0) $display("FAIL rst_tvalid got %b want 0", m_if.tvalid); else passed++;
    total++; if (m_if.tdata !== 32'h0) $display("FAIL rst_tdata got %h want 0", m_if.tdata); else passed++;
    total++; if (m_if.tlast !== 1'b0) $display("FAIL rst_tlast got %b want 0", m_if.tlast); else passed++;
    total++; if (s_if.tready !== 1'b0) $display("FAIL rst_tready_first got %b want 0", s_if.tready); else passed++;
    total++; if (in_packet !== 1'b0) $display("FAIL rst_in_packet got %b want 0", in_packet); else passed++;
    @(posedge clk); #2;
    total++; if (s_if.tready !== 1'b1) $display("FAIL rst_tready_after got %b want 1", s_if.tready); else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_puncture_basic();
    logic [31:0] b;
    b = 32'hA000_0000;
    set_cfg(5'd4, 16'b1011, 1'b0);
    outq.delete(); stalls = 0;
    for (int i = 0; i < 3; i++) send_beat(b + 32'(i), 1'b0);
    total++; if (in_packet !== 1'b1) $display("FAIL basic_in_packet_mid got %b want 1", in_packet); else passed++;
    for (int i = 3; i < 8; i++) send_beat(b + 32'(i), i == 7);
    total++; if (stalls !== 0) $display("FAIL basic_stalls got %0d want 0", stalls); else passed++;
    drain(6);
    total++; if (in_packet !== 1'b0) $display("FAIL basic_in_packet_end got %b want 0", in_packet); else passed++;
    exp_q = '{{1'b0, b+32'd0}, {1'b0, b+32'd1}, {1'b0, b+32'd3}, {1'b0, b+32'd4}, {1'b0, b+32'd5}, {1'b1, b+32'd7}};
    total++; if (outq.size() !== exp_q.size()) $display("FAIL basic_count got %0d want %0d", outq.size(), exp_q.size()); else passed++;
    foreach (exp_q[i]) if (i < outq.size()) begin
      total++; if (outq[i] !== exp_q[i]) $display("FAIL basic_word%0d got %h want %h", i, outq[i], exp_q[i]); else passed++;
    end
  endtask

  task automatic test_puncture_last_dropped();
    logic [31:0] b;
    b = 32'hB000_0000;
    set_cfg(5'd3, 16'b011, 1'b0);
    outq.delete();
    send_pkt(b, 6);
    drain(4);
    exp_q = '{{1'b0, b+32'd0}, {1'b0, b+32'd1}, {1'b0, b+32'd3}, {1'b1, b+32'd4}};
    total++; if (outq.size() !== exp_q.size()) $display("FAIL lastdrop_count got %0d want %0d", outq.size(), exp_q.size()); else passed++;
    foreach (exp_q[i]) if (i < outq.size()) begin
      total++; if (outq[i] !== exp_q[i]) $display("FAIL lastdrop_word%0d got %h want %h", i, outq[i], exp_q[i]); else passed++;
    end
  endtask

  task automatic test_puncture_all_zero();
    logic [31:0] b;
    b = 32'hC000_0000;
    set_cfg(5'd5, 16'h0000, 1'b0);
    outq.delete();
    send_pkt(b, 5);
    drain(0);
    total++; if (outq.size() !== 0) $display("FAIL allzero_count got %0d want 0", outq.size()); else passed++;
    total++; if (in_packet !== 1'b0) $display("FAIL allzero_in_packet got %b want 0", in_packet); else passed++;
    set_cfg(5'd1, 16'h0001, 1'b0);
    outq.delete();
    send_pkt(b + 32'h100, 3);
    drain(3);
    exp_q = '{{1'b0, b+32'h100}, {1'b0, b+32'h101}, {1'b1, b+32'h102}};
    total++; if (outq.size() !== exp_q.size()) $display("FAIL allzero_next_count got %0d want %0d", outq.size(), exp_q.size()); else passed++;
    foreach (exp_q[i]) if (i < outq.size()) begin
      total++; if (outq[i] !== exp_q[i]) $display("FAIL allzero_next_word%0d got %h want %h", i, outq[i], exp_q[i]); else passed++;
    end
  endtask

  task automatic test_depuncture();
    logic [31:0] b;
    b = 32'hD000_0000;
    set_cfg(5'd3, 16'b101, 1'b1);
    outq.delete();
    send_pkt(b, 4);
    drain(6);
    exp_q = '{{1'b0, b+32'd0}, {1'b0, FILL}, {1'b0, b+32'd1}, {1'b0, b+32'd2}, {1'b0, FILL}, {1'b1, b+32'd3}};
    total++; if (outq.size() !== exp_q.size()) $display("FAIL depunct_count got %0d want %0d", outq.size(), exp_q.size()); else passed++;
    foreach (exp_q[i]) if (i < outq.size()) begin
      total++; if (outq[i] !== exp_q[i]) $display("FAIL depunct_word%0d got %h want %h", i, outq[i], exp_q[i]); else passed++;
    end
    set_cfg(5'd3, 16'h0000, 1'b1);
    outq.delete();
    send_pkt(b + 32'h10, 3);
    drain(3);
    exp_q = '{{1'b0, b+32'h10}, {1'b0, b+32'h11}, {1'b1, b+32'h12}};
    total++; if (outq.size() !== exp_q.size()) $display("FAIL depunct_zero_count got %0d want %0d", outq.size(), exp_q.size()); else passed++;
    foreach (exp_q[i]) if (i < outq.size()) begin
      total++; if (outq[i] !== exp_q[i]) $display("FAIL depunct_zero_word%0d got %h want %h", i, outq[i], exp_q[i]); else passed++;
    end
  endtask

  task automatic test_reconfig();
    logic [31:0] b;
    b = 32'hE000_0000;
    set_cfg(5'd4, 16'b0110, 1'b0);
    outq.delete();
    for (int i = 0; i < 3; i++) send_beat(b + 32'(i), 1'b0);
    cfg_len = 5'd2; cfg_len_stb = 1'b1;
    @(posedge clk); #1;
    cfg_len_stb = 1'b0;
    for (int i = 3; i < 8; i++) send_beat(b + 32'(i), i == 7);
    drain(4);
    exp_q = '{{1'b0, b+32'd1}, {1'b0, b+32'd2}, {1'b0, b+32'd5}, {1'b1, b+32'd6}};
    total++; if (outq.size() !== exp_q.size()) $display("FAIL reconfig_old_count got %0d want %0d", outq.size(), exp_q.size()); else passed++;
    foreach (exp_q[i]) if (i < outq.size()) begin
      total++; if (outq[i] !== exp_q[i]) $display("FAIL reconfig_old_word%0d got %h want %h", i, outq[i], exp_q[i]); else passed++;
    end
    outq.delete();
    send_pkt(b + 32'h20, 6);
    drain(3);
    exp_q = '{{1'b0, b+32'h21}, {1'b0, b+32'h23}, {1'b1, b+32'h25}};
    total++; if (outq.size() !== exp_q.size()) $display("FAIL reconfig_new_count got %0d want %0d", outq.size(), exp_q.size()); else passed++;
    foreach (exp_q[i]) if (i < outq.size()) begin
      total++; if (outq[i] !== exp_q[i]) $display("FAIL reconfig_new_word%0d got %h want %h", i, outq[i], exp_q[i]); else passed++;
    end
  endtask

  task automatic test_random_backpressure_reset();
    logic [31:0] b;
    int          n0;
    b = 32'hF000_0000;
    set_cfg(5'd4, 16'b1011, 1'b0);
    rnd_en = 1'b1;
    outq.delete();
    send_pkt(b, 8);
    drain(6);
    exp_q = '{{1'b0, b+32'd0}, {1'b0, b+32'd1}, {1'b0, b+32'd3}, {1'b0, b+32'd4}, {1'b0, b+32'd5}, {1'b1, b+32'd7}};
    total++; if (outq.size() !== exp_q.size()) $display("FAIL rnd_count got %0d want %0d", outq.size(), exp_q.size()); else passed++;
    foreach (exp_q[i]) if (i < outq.size()) begin
      total++; if (outq[i] !== exp_q[i]) $display("FAIL rnd_word%0d got %h want %h", i, outq[i], exp_q[i]); else passed++;
    end
    outq.delete();
    for (int i = 0; i < 5; i++) send_beat(b + 32'h40 + 32'(i), 1'b0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    exp_q = '{{1'b0, b+32'h40}, {1'b0, b+32'h41}, {1'b0, b+32'h43}};
    total++; if (outq.size() > 3) $display("FAIL rstmid_count got %0d want at most 3", outq.size()); else passed++;
    foreach (exp_q[i]) if (i < outq.size()) begin
      total++; if (outq[i] !== exp_q[i]) $display("FAIL rstmid_word%0d got %h want %h", i, outq[i], exp_q[i]); else passed++;
    end
    n0 = outq.size();
    repeat (10) @(posedge clk);
    #1;
    total++; if (outq.size() !== n0) $display("FAIL rstmid_empty got %0d words want %0d", outq.size(), n0); else passed++;
    total++; if (in_packet !== 1'b0) $display("FAIL rstmid_in_packet got %b want 0", in_packet); else passed++;
    outq.delete();
    send_pkt(b + 32'h80, 10);
    drain(10);
    total++; if (outq.size() !== 10) $display("FAIL rstafter_count got %0d want 10", outq.size()); else passed++;
    for (int i = 0; i < 10; i++) if (i < outq.size()) begin
      total++;
      if (outq[i] !== {i == 9, b + 32'h80 + 32'(i)})
        $display("FAIL rstafter_word%0d got %h want %h", i, outq[i], {i == 9, b + 32'h80 + 32'(i)});
      else passed++;
    end
    rnd_en = 1'b0;
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0;
    cfg_len = '0; cfg_len_stb = 1'b0;
    cfg_vector = '0; cfg_vector_stb = 1'b0;
    cfg_mode = 1'b0; cfg_mode_stb = 1'b0;
    s_if.tdata = '0; s_if.tlast = 1'b0; s_if.tvalid = 1'b0;
`ifdef PUNCTURE_DEPUNCTURE_STATS_EN
    stat_clr = 1'b0;
`endif
    test_reset();
    test_puncture_basic();
    test_puncture_last_dropped();
    test_puncture_all_zero();
    test_depuncture();
    test_reconfig();
    test_random_backpressure_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/puncture_depuncture.md
Name: puncture_depuncture

Overview:
- Packet-aware, runtime-configurable puncture/depuncture engine for AXI-Stream sample or soft-bit streams.
- Puncture mode drops input words whose vector bit is 0.
- Depuncture mode inserts FILL_VALUE words at vector-0 positions without consuming input.
- The pattern restarts at every packet. Configuration commits only between packets. tlast is preserved when the final beat is punctured. Sits between a FEC encoder/decoder and the RFNoC packetizer.

Parameters:
- WIDTH, 32: data width.
- MAX_LEN, 16: maximum vector length.
- DEFAULT_LEN, 8: reset vector length.
- DEFAULT_VECTOR, 16'h00FF: reset vector; bit i applies to pattern position i.
- DEFAULT_MODE, 0: reset mode; 0 = puncture, 1 = depuncture.
- FILL_VALUE, 0: WIDTH-bit word inserted in depuncture mode.

Ports:
- clk  in  1  clock
- reset  in  1  reset
- clear  in  1  synchronous flush; same effect as reset
- cfg_len  in  $clog2(MAX_LEN+1)  vector length; 0 means MAX_LEN
- cfg_len_stb  in  1  write cfg_len to shadow
- cfg_vector  in  MAX_LEN  puncture vector
- cfg_vector_stb  in  1  write cfg_vector to shadow
- cfg_mode  in  1  mode
- cfg_mode_stb  in  1  write cfg_mode to shadow
- i_tdata  in  WIDTH;  i_tlast  in  1;  i_tvalid  in  1;  i_tready  out  1
- o_tdata  out  WIDTH;  o_tlast  out  1;  o_tvalid  out  1;  o_tready  in  1
- in_packet  out  1  high from first accepted input beat to acceptance of the tlast beat

Behaviour:
- Reset/clear: reset is synchronous, active-high, clock clk.
  - o_tvalid=0, o_tlast=0, o_tdata=0, i_tready=0 for one cycle, then per rules below, in_packet=0, index=0.
  - Active and shadow config take DEFAULT_* values; buffered words are discarded.
  - Reset mid-packet discards the partial packet with no tlast emitted.
- Config:
  - A strobe updates the shadow register in the same cycle.
  - Shadow is copied to active whenever in_packet=0 and no input beat is accepted that cycle, so a change takes effect on the next packet only.
  - Strobes and commit in the same cycle: the new strobe value wins next cycle.
- Index:
  - Counts 0..len-1 and wraps to 0.
  - Forced to 0 on packet end (after tlast beat handled).
  - bit = active_vector[index].
- Puncture mode:
  - Each accepted input beat advances index.
  - bit=1 beat is kept; bit=0 beat is dropped.
  - Output uses a 2-entry buffer plus a 1-word hold register. The last kept word is held until:
    - the next kept word arrives: the held word moves to the buffer with tlast=0; or
    - the tlast beat is accepted: if the tlast beat is dropped, the held word goes out with tlast=1; if kept, the held word goes out with tlast=0, then the tlast beat with tlast=1.
  - A packet whose every beat is dropped produces no output.
  - i_tready=0 when the buffer cannot absorb the worst case of 2 words.
  - Latency: a kept non-final word is visible 1 cycle after the next kept word or tlast beat is accepted.
  - Throughput: 1 word/cycle with o_tready=1.
- Depuncture mode:
  - Acts only while i_tvalid=1, so no fills are emitted between packets.
  - bit=1: pass the input word (i_tready=o_tready when output empty or draining), advance index.
  - bit=0: emit FILL_VALUE with tlast=0, i_tready=0, advance index on output handshake.
  - o_tlast accompanies the input tlast word; no trailing fills.
  - Registered output; latency 1 cycle.
  - An all-zero active vector in depuncture mode is treated as all-ones.
- Backpressure: o_tdata/o_tlast stable while o_tvalid=1 and o_tready=0. Must never lose or duplicate words.

Optional Feature:
- Macro PUNCTURE_DEPUNCTURE_STATS_EN.
- When defined, adds outputs:
  - stat_dropped, 32-bit: counts punctured words.
  - stat_inserted, 32-bit: counts fill words.
  - stat_clr, input: synchronous clear of both counters.
  - Counters saturate at 32'hFFFF_FFFF and are cleared by reset/clear.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
- Puncture, len=4, vector=4'b1011, 8-beat packet D0..D7 with tlast on D7 → output D0,D1,D3,D4,D5,D7; tlast on D7.
- Puncture, len=3, vector=3'b011, packet D0..D5, last D5 punctured → output D0,D1,D3,D4; tlast on D4.
- Puncture, vector=0, 5-beat packet → no output; the next packet with vector 1 passes intact.
- Depuncture, len=3, vector=3'b101, input A,B,C,D with tlast on D → output A,F,B,C,F,D (F=FILL_VALUE); tlast on D.
- Reconfig: write len=2 mid-packet → current packet keeps the old pattern; the next packet uses len=2 from index 0.
- Random o_tready at 50% plus reset asserted mid-packet → output matches the reference model up to reset, then empty; the following packet is correct.
